// File: rtl/boxcar_average_filter_if.sv
// Sample/control/result bundle for the boxcar averaging filter.
// master drives samples and controls; slave is the filter.
interface boxcar_average_filter_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_LOG2 = 10
);
    localparam int unsigned ACC_W = DATA_W + MAX_LOG2;

    logic [3:0]               log2_len;
    logic                     avg_mode;
    logic                     flush;
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_in_valid;
    logic signed [ACC_W-1:0]  sum_out;
    logic signed [DATA_W-1:0] avg_out;
    logic                     out_valid;
    logic                     filled;

    modport master (
        output log2_len,
        output avg_mode,
        output flush,
        output sample_in,
        output sample_in_valid,
        input  sum_out,
        input  avg_out,
        input  out_valid,
        input  filled
    );

    modport slave (
        input  log2_len,
        input  avg_mode,
        input  flush,
        input  sample_in,
        input  sample_in_valid,
        output sum_out,
        output avg_out,
        output out_valid,
        output filled
    );
endinterface

// File: rtl/boxcar_average_filter.sv
// Running-sum boxcar filter over the last 2^log2_len samples, backed by a
// circular history RAM with one synchronous read port. Two-cycle latency.
module boxcar_average_filter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_LOG2 = 10
) (
    input logic                    clk,
    input logic                    rst,
    boxcar_average_filter_if.slave bus
);
    localparam int unsigned ACC_W = DATA_W + MAX_LOG2;
    localparam int unsigned DEPTH = 1 << MAX_LOG2;

    localparam logic [1:0] StClear = 2'd0;
    localparam logic [1:0] StFill  = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;

    localparam logic [3:0]          MaxLen = 4'(MAX_LOG2);
    localparam logic [MAX_LOG2:0]   WinOne = (MAX_LOG2 + 1)'(1);
    localparam logic [MAX_LOG2-1:0] WpOne  = MAX_LOG2'(1);

    logic [1:0]              state_q, state_d;
    logic [3:0]              len_q, len_clamped;
    logic [MAX_LOG2:0]       win_n, cnt_q, cnt_d;
    logic [MAX_LOG2-1:0]     wp_q, wp_d, rd_addr;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
    logic signed [ACC_W-1:0] s1_ext, rd_ext;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] s1_sample_q;

    logic s1_valid_q, s1_valid_d;
    logic s1_sub_q, s1_sub_d;
    logic s1_emit_q, s1_emit_d;
    logic s2_emit_q, s2_emit_d;
    logic out_valid_q, out_valid_d;
    logic clear_req, accept, last_fill;

    always_comb begin
        len_clamped = (bus.log2_len > MaxLen) ? MaxLen : bus.log2_len;
        win_n       = WinOne << len_q;
        last_fill   = ((cnt_q + WinOne) == win_n);
        clear_req   = bus.flush || (len_clamped != len_q);
        accept      = bus.sample_in_valid && !clear_req && (state_q != StClear);
        // Oldest sample in the window; for N = DEPTH this aliases wp and relies on read-old-data.
        rd_addr     = wp_q - win_n[MAX_LOG2-1:0];
        s1_ext      = {{MAX_LOG2{s1_sample_q[DATA_W-1]}}, s1_sample_q};
        rd_ext      = {{MAX_LOG2{rd_q[DATA_W-1]}}, rd_q};
    end

    // Stage 1: accept + RAM read; stage 2: accumulate; stage 3: publish.
    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        s1_valid_d  = accept;
        s1_sub_d    = (state_q == StRun);
        s1_emit_d   = (state_q == StRun) || last_fill;
        s2_emit_d   = s1_valid_q && s1_emit_q;
        out_valid_d = s2_emit_q;
        sum_d       = s2_emit_q ? acc_q : sum_q;

        if (s1_valid_q) begin
            acc_d = s1_sub_q ? (acc_q + s1_ext - rd_ext) : (acc_q + s1_ext);
        end

        if (accept) begin
            wp_d = wp_q + WpOne;
            if (state_q == StFill) begin
                cnt_d = cnt_q + WinOne;
                if (last_fill) begin
                    state_d = StRun;
                end
            end
        end

        // Restart kills everything in flight, including results not yet published.
        if (clear_req || (state_q == StClear)) begin
            state_d     = clear_req ? StClear : StFill;
            wp_d        = '0;
            cnt_d       = '0;
            acc_d       = '0;
            sum_d       = '0;
            s1_valid_d  = 1'b0;
            s2_emit_d   = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StClear;
            // Tracks the input during reset so release sees no spurious length change.
            len_q       <= len_clamped;
            wp_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            s1_sample_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_emit_q   <= 1'b0;
            s2_emit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_clamped;
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            s1_sample_q <= bus.sample_in;
            s1_valid_q  <= s1_valid_d;
            s1_sub_q    <= s1_sub_d;
            s1_emit_q   <= s1_emit_d;
            s2_emit_q   <= s2_emit_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wp_q] <= bus.sample_in;
        end
        rd_q <= mem[rd_addr];
    end

    assign bus.sum_out   = sum_q;
    assign bus.avg_out   = bus.avg_mode ? DATA_W'(sum_q >>> len_q) : sum_q[DATA_W-1:0];
    assign bus.out_valid = out_valid_q;
    assign bus.filled    = (state_q == StRun);

endmodule

// File: tb/tb_boxcar_average_filter.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a queue-based window-sum model evaluated once per clock.
module tb_boxcar_average_filter;
    localparam int DW = 16;
    localparam int ML = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    boxcar_average_filter_if #(.DATA_W(DW), .MAX_LOG2(ML)) bif ();

    boxcar_average_filter #(.DATA_W(DW), .MAX_LOG2(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int tests = 0;
    int fails = 0;

    int unsigned cyc = 0;
    longint      win[$];
    int unsigned due_q[$];
    longint      sum_q[$];
    int          m_len   = 2;
    bit          m_block = 1'b1;
    bit          m_hold  = 1'b0;
    longint      m_sum   = 0;

    logic [3:0] cur_len  = 4'd2;
    logic       cur_mode = 1'b1;

    longint dut_peak;
    longint dut_last;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0b expected %0b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int clamp_len(input logic [3:0] l);
        return (l > 4'd10) ? 10 : int'(l);
    endfunction

    task automatic check_held();
        longint             a;
        logic signed [15:0] a16;
        logic signed [25:0] s26;
        if (m_hold) begin
            a   = cur_mode ? (m_sum >>> m_len) : m_sum;
            a16 = a[15:0];
            s26 = m_sum[25:0];
            check_val("sum_out", bif.sum_out, s26);
            check_val("avg_out", bif.avg_out, a16);
        end
    endtask

    // Entered and left at a negedge; drives one cycle of inputs.
    task automatic step(input bit v, input logic signed [15:0] s, input bit fl);
        int     cl;
        int     n;
        longint sm;
        bit     ev;
        bif.sample_in_valid = v;
        bif.sample_in       = s;
        bif.flush           = fl;
        bif.log2_len        = cur_len;
        bif.avg_mode        = cur_mode;
        @(posedge clk);
        cyc++;
        cl = clamp_len(cur_len);
        if (fl || cl != m_len) begin
            win.delete();
            due_q.delete();
            sum_q.delete();
            m_block = 1'b1;
            m_hold  = 1'b0;
            m_len   = cl;
        end else if (m_block) begin
            m_block = 1'b0;
        end else if (v) begin
            win.push_back(longint'(s));
            if (win.size() > 1024) void'(win.pop_front());
            n = 1 << m_len;
            if (win.size() >= n) begin
                sm = 0;
                for (int i = win.size() - n; i < win.size(); i++) sm += win[i];
                due_q.push_back(cyc + 2);
                sum_q.push_back(sm);
            end
        end
        ev = 1'b0;
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            ev = 1'b1;
            void'(due_q.pop_front());
            m_sum  = sum_q.pop_front();
            m_hold = 1'b1;
        end
        #1;
        check_bit("out_valid", bif.out_valid, ev);
        check_bit("filled", bif.filled, win.size() >= (1 << m_len));
        check_held();
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 16'sd0, 1'b0);
    endtask

    task automatic do_reset(input int k);
        rst = 1'b0;
        win.delete();
        due_q.delete();
        sum_q.delete();
        m_hold = 1'b0;
        #1;
        check_bit("rst_out_valid", bif.out_valid, 1'b0);
        check_val("rst_sum_out", bif.sum_out, 64'sd0);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            check_bit("rst_out_valid", bif.out_valid, 1'b0);
            check_bit("rst_filled", bif.filled, 1'b0);
            check_val("rst_sum_out", bif.sum_out, 64'sd0);
            check_val("rst_avg_out", bif.avg_out, 64'sd0);
        end
        @(negedge clk);
        rst     = 1'b1;
        m_block = 1'b1;
        m_len   = clamp_len(cur_len);
    endtask

    initial begin
        int         seq_a[5];
        logic [3:0] lens[8];
        bit         v;
        bit         fl;
        logic signed [15:0] s;

        seq_a = '{4, 8, 12, 16, 20};
        lens  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11, 4'd15};

        bif.sample_in_valid = 1'b1;
        bif.sample_in       = 16'sd77;
        bif.flush           = 1'b0;
        bif.log2_len        = cur_len;
        bif.avg_mode        = cur_mode;
        @(negedge clk);
        do_reset(3);

        // Window of 4, mean mode.
        foreach (seq_a[i]) step(1'b1, 16'(seq_a[i]), 1'b0);
        idle(3);
        cur_mode = 1'b0;
        idle(2);
        cur_mode = 1'b1;

        // Passthrough.
        cur_len = 4'd0;
        idle(2);
        step(1'b1, -16'sd5, 1'b0);
        step(1'b1, 16'sd7, 1'b0);
        idle(3);

        // Floor rounding of a negative mean.
        cur_len = 4'd3;
        idle(2);
        for (int i = 0; i < 8; i++) step(1'b1, -16'sd1, 1'b0);
        step(1'b1, 16'sd0, 1'b0);
        idle(3);

        // Length change while running.
        cur_len = 4'd2;
        for (int i = 0; i < 7; i++) step(1'b1, 16'(i * 3 - 5), 1'b0);
        cur_len = 4'd3;
        for (int i = 0; i < 11; i++) step(1'b1, 16'(100 - i * 9), 1'b0);
        idle(3);

        // Flush colliding with a valid sample.
        step(1'b1, 16'sd999, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 16'(i + 1), 1'b0);
        idle(3);

        // Full-depth window at full scale.
        cur_len  = 4'd10;
        dut_peak = -64'sd1 <<< 40;
        idle(2);
        for (int i = 0; i < 2048; i++) begin
            step(1'b1, (i < 1024) ? 16'sd32767 : -16'sd32768, 1'b0);
            if (bif.out_valid === 1'b1 && longint'(bif.sum_out) > dut_peak)
                dut_peak = longint'(bif.sum_out);
        end
        idle(3);
        dut_last = longint'(bif.sum_out);
        check_val("full_scale_peak", dut_peak, 64'sd33553408);
        check_val("full_scale_end", dut_last, -64'sd33554432);

        // Reset mid-window.
        cur_len = 4'd3;
        idle(2);
        for (int i = 0; i < 10; i++) step(1'b1, 16'(i * 7), 1'b0);
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1'b1, 16'(-i * 11), 1'b0);
        idle(3);

        // Random traffic, including clamped lengths and flushes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) cur_len = lens[$urandom_range(0, 7)];
            cur_mode = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 9))
                0:       s = 16'sh7fff;
                1:       s = -16'sh8000;
                default: s = 16'($urandom);
            endcase
            step(v, s, fl);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
